// File: rtl/aes_key_expand.sv
// -----------------------------------------------------------------------------
// aes_key_expand
//
// Iterative AES-128 key schedule. A key_load strobe captures the cipher key as
// round key 0, then one further round key is produced per clock until round
// key 10 is written. All eleven round keys live in an internal register file
// that the encrypt core reads by index with one cycle of latency.
//
// Ports:
//   clk        in   1    rising-edge clock
//   reset      in   1    synchronous, active-high; clears state and key store
//   key_load   in   1    single-cycle strobe; samples cipher_key, (re)starts
//   cipher_key in   128  key, byte 0 in bits [127:120]
//   key_busy   out  1    expansion in progress
//   key_ready  out  1    all 11 round keys valid
//   rk_idx     in   4    round-key read index (0..10; larger reads zero)
//   round_key  out  128  registered read data for rk_idx of previous cycle
// -----------------------------------------------------------------------------
module aes_key_expand (
    input  logic         clk,
    input  logic         reset,
    input  logic         key_load,
    input  logic [127:0] cipher_key,
    output logic         key_busy,
    output logic         key_ready,
    input  logic [3:0]   rk_idx,
    output logic [127:0] round_key
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic [31:0]  w_q [4];
    logic [31:0]  w_d [4];
    logic [127:0] rk_q [11];
    logic [127:0] rk_d [11];
    logic [127:0] round_key_q, round_key_d;
    logic         key_busy_q, key_busy_d;
    logic         key_ready_q, key_ready_d;

    logic [31:0]  rot_word;
    logic [31:0]  sub_word;
    logic [31:0]  temp;
    logic [31:0]  nw0, nw1, nw2, nw3;

    // GF(2^8) multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (square-and-multiply); maps 0 to 0,
    // which is exactly what the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    // S-box = affine transform of the field inverse.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // One key-schedule round on the working words; the four byte
    // substitutions here are the only S-boxes and serve every round.
    always_comb begin
        rot_word = {w_q[3][23:0], w_q[3][31:24]};
        sub_word = {sbox(rot_word[31:24]), sbox(rot_word[23:16]),
                    sbox(rot_word[15:8]),  sbox(rot_word[7:0])};
        temp     = sub_word ^ {rcon(round_q), 24'h000000};
        nw0      = w_q[0] ^ temp;
        nw1      = w_q[1] ^ nw0;
        nw2      = w_q[2] ^ nw1;
        nw3      = w_q[3] ^ nw2;
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        for (int i = 0; i < 4; i++)  w_d[i]  = w_q[i];
        for (int i = 0; i < 11; i++) rk_d[i] = rk_q[i];

        if (key_load) begin
            // Same action from any state; a load during EXPAND simply
            // restarts, leaving stale higher round keys to be overwritten.
            state_d = EXPAND;
            round_d = 4'd1;
            rk_d[0] = cipher_key;
            w_d[0]  = cipher_key[127:96];
            w_d[1]  = cipher_key[95:64];
            w_d[2]  = cipher_key[63:32];
            w_d[3]  = cipher_key[31:0];
        end else begin
            case (state_q)
                IDLE, READY: ;
                EXPAND: begin
                    rk_d[round_q] = {nw0, nw1, nw2, nw3};
                    w_d[0] = nw0;
                    w_d[1] = nw1;
                    w_d[2] = nw2;
                    w_d[3] = nw3;
                    if (round_q == 4'd10) begin
                        state_d = READY;
                    end else begin
                        round_d = round_q + 4'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Flags are registered from the next state so they line up with it.
        key_busy_d  = (state_d == EXPAND);
        key_ready_d = (state_d == READY);

        // Read port ignores state; out-of-range indices return zero.
        round_key_d = (rk_idx <= 4'd10) ? rk_q[rk_idx] : 128'h0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            round_q     <= 4'd0;
            for (int i = 0; i < 4; i++)  w_q[i]  <= 32'h0;
            for (int i = 0; i < 11; i++) rk_q[i] <= 128'h0;
            round_key_q <= 128'h0;
            key_busy_q  <= 1'b0;
            key_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            for (int i = 0; i < 4; i++)  w_q[i]  <= w_d[i];
            for (int i = 0; i < 11; i++) rk_q[i] <= rk_d[i];
            round_key_q <= round_key_d;
            key_busy_q  <= key_busy_d;
            key_ready_q <= key_ready_d;
        end
    end

    assign key_busy  = key_busy_q;
    assign key_ready = key_ready_q;
    assign round_key = round_key_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// -----------------------------------------------------------------------------
// tb_aes_key_expand
//
// Directed and random stimulus for aes_key_expand. Expected round keys come
// from a FIPS-197 word-oriented key-schedule model built on a table S-box.
// Read-port results are queued when an index is driven and compared when the
// registered data appears one cycle later.
// -----------------------------------------------------------------------------
module tb_aes_key_expand;

    logic         clk = 1'b0;
    logic         reset;
    logic         key_load;
    logic [127:0] cipher_key;
    logic         key_busy;
    logic         key_ready;
    logic [3:0]   rk_idx;
    logic [127:0] round_key;

    aes_key_expand dut (
        .clk        (clk),
        .reset      (reset),
        .key_load   (key_load),
        .cipher_key (cipher_key),
        .key_busy   (key_busy),
        .key_ready  (key_ready),
        .rk_idx     (rk_idx),
        .round_key  (round_key)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [127:0] exp_q [$];
    string        tag_q [$];
    logic [127:0] exp_rk [11];

    logic [127:0] sbox_rows [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };
    logic [7:0] rcon_tbl [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    logic [127:0] k1, k2, ka5, rkey;

    function automatic logic [7:0] sb(input logic [7:0] b);
        logic [127:0] row;
        int           c;
        row = sbox_rows[b[7:4]];
        c   = int'(b[3:0]);
        return row[(15 - c) * 8 +: 8];
    endfunction

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])}
                    ^ {rcon_tbl[i / 4 - 1], 24'h000000};
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            exp_rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_check();
        logic [127:0] e;
        string        t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk(t, round_key, e);
    endtask

    // Present an index this cycle; the result due from the previous index is
    // compared after the new index is already driven.
    task automatic rd(input logic [3:0] idx, input logic [127:0] exp, input string tag);
        rk_idx = idx;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        #2;
        if (exp_q.size() > 1) pop_check();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_flush();
        rk_idx = 4'hf;
        #2;
        while (exp_q.size() > 0) pop_check();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_all(input string pfx);
        for (int r = 0; r < 11; r++)
            rd(4'(r), exp_rk[r], $sformatf("%s_rk%0d", pfx, r));
        rd_flush();
    endtask

    task automatic rd_zero(input string pfx);
        for (int r = 0; r < 16; r++)
            rd(4'(r), 128'h0, $sformatf("%s_zero%0d", pfx, r));
        rd_flush();
    endtask

    // Leaves the bench in cycle N+1 relative to the load edge.
    task automatic load_key(input logic [127:0] key);
        cipher_key = key;
        key_load   = 1'b1;
        tick();
        key_load   = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int cnt;
        cnt = 1;
        while (key_ready !== 1'b1 && cnt < 40) begin
            chk({tag, "_busy"}, 128'(key_busy), 128'h1);
            tick();
            cnt++;
        end
        chk({tag, "_latency"}, 128'(cnt), 128'd11);
        chk({tag, "_ready"}, 128'(key_ready), 128'h1);
        chk({tag, "_busy_off"}, 128'(key_busy), 128'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        k1  = 128'h000102030405060708090a0b0c0d0e0f;
        k2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        ka5 = {16{8'ha5}};

        reset = 1'b1; key_load = 1'b0; cipher_key = 128'h0; rk_idx = 4'd0;
        repeat (3) tick();
        chk("rst_busy", 128'(key_busy), 128'h0);
        chk("rst_ready", 128'(key_ready), 128'h0);
        chk("rst_round_key", round_key, 128'h0);
        reset = 1'b0;
        tick();
        chk("idle_busy", 128'(key_busy), 128'h0);
        rd_zero("init");

        model_expand(k1);
        load_key(k1);
        chk("k1_ready_low", 128'(key_ready), 128'h0);
        wait_ready("k1");
        rd(4'd1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe, "k1_kat_rk1");
        rd(4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "k1_kat_rk10");
        rd(4'd0,  k1, "k1_kat_rk0");
        rd_flush();
        rd_all("k1");
        repeat (3) tick();
        chk("k1_ready_hold", 128'(key_ready), 128'h1);

        model_expand(k2);
        load_key(k2);
        chk("k2_ready_drop", 128'(key_ready), 128'h0);
        wait_ready("k2");
        rd(4'd1,  128'ha0fafe1788542cb123a339392a6c7605, "k2_kat_rk1");
        rd(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "k2_kat_rk10");
        rd_flush();
        rd_all("k2");

        load_key(k1);
        repeat (3) begin
            chk("restart_busy_pre", 128'(key_busy), 128'h1);
            tick();
        end
        load_key(k2);
        chk("restart_ready_low", 128'(key_ready), 128'h0);
        wait_ready("restart");
        rd(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "restart_kat_rk10");
        rd_flush();
        rd_all("restart");

        model_expand(ka5);
        load_key(ka5);
        chk("a5_ready_drop", 128'(key_ready), 128'h0);
        wait_ready("a5");
        rd_all("a5");

        for (int r = 11; r < 16; r++)
            rd(4'(r), 128'h0, $sformatf("oor_idx%0d", r));
        rd_flush();

        load_key(k1);
        repeat (4) tick();
        chk("midrst_busy_pre", 128'(key_busy), 128'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_busy", 128'(key_busy), 128'h0);
        chk("midrst_ready", 128'(key_ready), 128'h0);
        chk("midrst_round_key", round_key, 128'h0);
        rd_zero("midrst");
        chk("midrst_idle_busy", 128'(key_busy), 128'h0);
        chk("midrst_idle_ready", 128'(key_ready), 128'h0);

        cipher_key = k2;
        key_load   = 1'b1;
        reset      = 1'b1;
        tick();
        key_load   = 1'b0;
        reset      = 1'b0;
        chk("rstload_busy", 128'(key_busy), 128'h0);
        chk("rstload_ready", 128'(key_ready), 128'h0);
        tick();
        chk("rstload_busy2", 128'(key_busy), 128'h0);
        rd(4'd0,  128'h0, "rstload_rk0");
        rd(4'd10, 128'h0, "rstload_rk10");
        rd_flush();

        for (int n = 0; n < 200; n++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            model_expand(rkey);
            load_key(rkey);
            wait_ready($sformatf("rnd%0d", n));
            rd_all($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
